// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types, field offsets and helpers for the HUB75 scan driver
package hub75_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;
    typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;
    localparam int HALF_BIT = 11;
    localparam int ROW_LSB = 6;
    function automatic logic [HALF_BIT:0] pix_addr(
        input logic half,
        input logic [HALF_BIT-ROW_LSB-1:0] row,
        input logic [ROW_LSB-1:0] col
    );
        return {half, row, col};
    endfunction
    function automatic logic [2:0] rgb_bits(input logic [23:0] pix, input logic [4:0] idx);
        return {pix[idx + 5'(R_LSB)], pix[idx + 5'(G_LSB)], pix[idx + 5'(B_LSB)]};
    endfunction
endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: load-and-count-down display timer, done marks the last display cycle
module hub75_bcm_timer #(
    parameter int W = 7
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] ticks,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= ticks;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end
    assign done = cnt == W'(1);
endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: 1/32-scan HUB75 driver with BCM brightness; HUB75_BLANK_GUARD_EN adds 2 blank cycles around latch
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int HALF_ROWS  = 32,
    parameter int PWM_BITS   = 4,
    parameter int BASE_TICKS = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] pixel_data,
    output logic [11:0] pixel_addr,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        r2,
    output logic        g2,
    output logic        b2,
    output logic        panel_clk,
    output logic        latch,
    output logic        oe_n,
    output logic [4:0]  row_addr,
    output logic        frame_start
);
    localparam int TW = $clog2(BASE_TICKS << (PWM_BITS - 1)) + 1;
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(HALF_ROWS - 1);
    localparam logic [2:0] LAST_PLANE = 3'(PWM_BITS - 1);

    state_t         state;
    phase_t         phase;
    logic [5:0]     col;
    logic [4:0]     row;
    logic [2:0]     plane;
    logic [2:0]     up;
    logic [4:0]     idx;
    logic [4:0]     next_row;
    logic           plane_last;
    logic           frame_end;
    logic           load;
    logic           done;
    logic [TW-1:0]  ticks;

    // Plane p shows the channel bit 8-PWM_BITS+p, i.e. the top PWM_BITS bits
    assign idx        = 5'(8 - PWM_BITS) + {2'b00, plane};
    assign plane_last = plane == LAST_PLANE;
    assign frame_end  = plane_last && row == LAST_ROW;
    assign next_row   = plane_last ? (frame_end ? 5'd0 : row + 5'd1) : row;
    assign ticks      = TW'(BASE_TICKS) << plane;

`ifdef HUB75_BLANK_GUARD_EN
    logic [2:0] gcnt;
    assign load = state == LATCH && gcnt == 3'd4;
`else
    assign load = state == LATCH;
`endif

    hub75_bcm_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .ticks (ticks),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= P0;
            col         <= '0;
            row         <= '0;
            plane       <= '0;
            up          <= '0;
            pixel_addr  <= '0;
            {r1, g1, b1, r2, g2, b2} <= '0;
            panel_clk   <= 1'b0;
            latch       <= 1'b0;
            oe_n        <= 1'b1;
            row_addr    <= '0;
            frame_start <= 1'b0;
`ifdef HUB75_BLANK_GUARD_EN
            gcnt        <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            // Rising shift edge lands one cycle after data settles, for every column incl. the last
            panel_clk   <= state == SHIFT && phase == P3;
            case (state)
                IDLE: if (enable) begin
                    state       <= SHIFT;
                    phase       <= P0;
                    col         <= '0;
                    row         <= '0;
                    plane       <= '0;
                    pixel_addr  <= pix_addr(1'b0, 5'd0, 6'd0);
                    frame_start <= 1'b1;
                end
                SHIFT: begin
                    phase <= phase_t'(phase + 2'd1);
                    case (phase)
                        P0: begin
                            pixel_addr <= pix_addr(1'b1, row, col);
                            up         <= rgb_bits(pixel_data, idx);
                        end
                        P2: {r1, g1, b1, r2, g2, b2} <= {up, rgb_bits(pixel_data, idx)};
                        P3: if (col == LAST_COL) begin
                            state    <= LATCH;
`ifdef HUB75_BLANK_GUARD_EN
                            gcnt     <= '0;
`else
                            latch    <= 1'b1;
                            row_addr <= row;
`endif
                        end else begin
                            col        <= col + 6'd1;
                            pixel_addr <= pix_addr(1'b0, row, col + 6'd1);
                        end
                        default: ;
                    endcase
                end
`ifdef HUB75_BLANK_GUARD_EN
                // gcnt 0,1 pre-guard, 2 latch, 3,4 post-guard; row select moves after the strobe
                LATCH: begin
                    gcnt  <= gcnt + 3'd1;
                    latch <= gcnt == 3'd1;
                    if (gcnt == 3'd2)
                        row_addr <= row;
                    if (gcnt == 3'd4) begin
                        state <= DISPLAY;
                        oe_n  <= 1'b0;
                    end
                end
`else
                LATCH: begin
                    latch <= 1'b0;
                    state <= DISPLAY;
                    oe_n  <= 1'b0;
                end
`endif
                DISPLAY: if (done) begin
                    oe_n        <= 1'b1;
                    plane       <= plane_last ? 3'd0 : plane + 3'd1;
                    row         <= next_row;
                    col         <= '0;
                    phase       <= P0;
                    pixel_addr  <= pix_addr(1'b0, next_row, 6'd0);
                    state       <= frame_end && !enable ? IDLE : SHIFT;
                    frame_start <= frame_end && enable;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: scoreboard bench for hub75_scan_driver (plain and HUB75_BLANK_GUARD_EN builds)
module tb_hub75_scan_driver;
`ifdef HUB75_BLANK_GUARD_EN
    localparam int FRAME = 37248;
    localparam int L2D   = 3;
    localparam int R2L   = 2;
`else
    localparam int FRAME = 36736;
    localparam int L2D   = 1;
    localparam int R2L   = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] pixel_data;
    logic [11:0] pixel_addr;
    logic        r1, g1, b1, r2, g2, b2;
    logic        panel_clk, latch, oe_n, frame_start;
    logic [4:0]  row_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [5:0] exp_q[$];
    int oe_q[$];
    int row_q[$];
    int fs_times[$];
    int rises = 0;
    int last_rise = 0;
    int last_latch = 0;
    int last_low = -1;
    int run = 0;
    logic prev_pclk = 1'b0;
    logic prev_oe = 1'b1;
    logic prev_fs = 1'b0;

    hub75_scan_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pixel_data  (pixel_data),
        .pixel_addr  (pixel_addr),
        .r1          (r1),
        .g1          (g1),
        .b1          (b1),
        .r2          (r2),
        .g2          (g2),
        .b2          (b2),
        .panel_clk   (panel_clk),
        .latch       (latch),
        .oe_n        (oe_n),
        .row_addr    (row_addr),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stub generator: pattern chosen by row[2:0] and half
    function automatic logic [23:0] gen(input logic [11:0] a);
        case (a[8:6])
            3'd0: return 24'hFF0000;
            3'd1: return 24'h800000;
            3'd2: return a[11] ? 24'h0000FF : 24'h000000;
            3'd3: return a[11] ? 24'h00F000 : 24'h0F0F0F;
            3'd4: return 24'h5A3CC3;
            3'd5: return a[11] ? 24'h000080 : 24'h100000;
            3'd6: return a[0] ? 24'hFFFFFF : 24'h000000;
            default: return a[11] ? 24'hA050F0 : 24'h30C060;
        endcase
    endfunction
    assign pixel_data = gen(pixel_addr);

    // Hand-derived top nibbles {R,G,B} of the patterns above
    function automatic logic [11:0] nib(input int r, input logic h, input int c);
        case (r % 8)
            0: return 12'hF00;
            1: return 12'h800;
            2: return h ? 12'h00F : 12'h000;
            3: return h ? 12'h0F0 : 12'h000;
            4: return 12'h53C;
            5: return h ? 12'h008 : 12'h100;
            6: return (c % 2 == 1) ? 12'hFFF : 12'h000;
            default: return h ? 12'hA5F : 12'h3C6;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_plane(input int r, input int p, input int ncol);
        logic [11:0] u, l;
        for (int c = 0; c < ncol; c++) begin
            u = nib(r, 1'b0, c);
            l = nib(r, 1'b1, c);
            exp_q.push_back({u[8+p], u[4+p], u[p], l[8+p], l[4+p], l[p]});
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < 32; r++)
            for (int p = 0; p < 4; p++) begin
                row_q.push_back(r);
                oe_q.push_back(8 << p);
                push_plane(r, p, 64);
            end
    endtask

    task automatic underflow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (panel_clk && !prev_pclk) begin
                rises++;
                last_rise = cyc;
                if (exp_q.size() == 0) underflow("shift_data_extra_rise");
                else chk("shift_data", int'({r1, g1, b1, r2, g2, b2}), int'(exp_q.pop_front()));
            end
            if (latch) begin
                chk("latch_rises", rises, 64);
                chk("latch_gap", cyc - last_rise, R2L);
                chk("latch_oe_n", int'(oe_n), 1);
                rises = 0;
                last_latch = cyc;
            end
            if (!oe_n) begin
                if (prev_oe) begin
                    if (row_q.size() == 0) underflow("display_extra");
                    else chk("display_row_addr", int'(row_addr), row_q.pop_front());
                    chk("latch_to_display", cyc - last_latch, L2D);
                    run = 0;
                end
                run++;
                last_low = cyc;
            end else if (!prev_oe) begin
                if (oe_q.size() == 0) underflow("oe_len_extra");
                else chk("oe_low_len", run, oe_q.pop_front());
            end
            if (frame_start) begin
                chk("frame_start_width", int'(prev_fs), 0);
                fs_times.push_back(cyc);
            end
        end
        prev_pclk = panel_clk;
        prev_oe   = oe_n;
        prev_fs   = frame_start;
    end

    initial begin
        int bad;
        int n;
        int t0;
        repeat (3) @(negedge clk);
        chk("rst_pixel_addr", int'(pixel_addr), 0);
        chk("rst_rgb", int'({r1, g1, b1, r2, g2, b2}), 0);
        chk("rst_panel_clk", int'(panel_clk), 0);
        chk("rst_latch", int'(latch), 0);
        chk("rst_oe_n", int'(oe_n), 1);
        chk("rst_row_addr", int'(row_addr), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!oe_n || latch || panel_clk || frame_start || pixel_addr != 12'd0) bad++;
        end
        chk("idle_hold_1000", bad, 0);

        push_frame();
        push_frame();
        enable = 1'b1;
        n = 0;
        while (fs_times.size() < 2 && n < FRAME + 200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_starts_seen", fs_times.size(), 2);
        t0 = fs_times.size() >= 2 ? fs_times[1] : cyc;
        if (fs_times.size() >= 2) chk("frame_period", fs_times[1] - fs_times[0], FRAME);

        n = 0;
        while (pixel_addr[10:6] != 5'd10 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        chk("row10_reached", int'(pixel_addr[10:6]), 10);
        enable = 1'b0;
        while (cyc < t0 + FRAME + 100) @(negedge clk);
        chk("frame_last_display", last_low - t0, FRAME - 1);
        chk("no_restart", fs_times.size(), 2);
        chk("idle_oe_n", int'(oe_n), 1);
        chk("data_queue_drained", exp_q.size(), 0);
        chk("oe_queue_drained", oe_q.size(), 0);
        chk("row_queue_drained", row_q.size(), 0);

        push_plane(0, 0, 30);
        enable = 1'b1;
        n = 0;
        while (pixel_addr != 12'd30 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reached_col30", int'(pixel_addr), 30);
        #1 rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("mid_rst_oe_n", int'(oe_n), 1);
        chk("mid_rst_latch", int'(latch), 0);
        chk("mid_rst_panel_clk", int'(panel_clk), 0);
        chk("mid_rst_pixel_addr", int'(pixel_addr), 0);
        chk("mid_rst_rgb", int'({r1, g1, b1, r2, g2, b2}), 0);
        @(negedge clk);
        chk("mid_rst_hold_oe_n", int'(oe_n), 1);
        chk("mid_rst_rises_consumed", exp_q.size(), 0);
        chk("frame_start_total", fs_times.size(), 3);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle_oe_n", int'(oe_n), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
